// File: rtl/axi_tdd_ng_pkg.sv
// Shared types and constants for the TDD next-gen engine and its sync generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_tdd_ng_pkg;

    // Common state encoding, also exported on the sync generator's state port
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAITING = 2'd2,
        RUNNING = 2'd3
    } state_t;

    // Shortest period that still leaves at least one low cycle per period
    localparam int SYNC_PERIOD_MIN = 2;

endpackage : axi_tdd_ng_pkg

// File: rtl/axi_tdd_ng_edge_det.sv
// Rising-edge detector: registers the input history and flags current=1 / previous=0.
// Latency: edge flag is combinational from the input, history updates every clock.
// Backpressure: none; the detector samples every cycle.
module axi_tdd_ng_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Remember the last sampled level so a held-high input never re-triggers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule : axi_tdd_ng_edge_det

// File: rtl/axi_tdd_ng_sync_gen.sv
// Periodic sync pulse generator: arm, optional trigger, startup delay, then pulses every period.
// Latency: sync_out registered, one cycle after the counter state that causes it.
// Backpressure: none; enable=0 aborts immediately. Macro AXI_TDD_NG_SYNC_GEN_RESYNC_EN adds ext_trig resync.
module axi_tdd_ng_sync_gen
    import axi_tdd_ng_pkg::*;
#(
    parameter int SYNC_COUNT_WIDTH = 64,
    parameter int SYNC_PULSE_WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        trigger_mode,
    input  logic                        ext_trig,
    input  logic                        soft_trig,
    input  logic [31:0]                 startup_delay,
    input  logic [SYNC_COUNT_WIDTH-1:0] sync_period,
    input  logic [31:0]                 burst_count,
    output logic                        sync_out,
    output logic [1:0]                  state,
    output logic [31:0]                 pulse_counter,
    output logic                        done
);

    localparam logic [SYNC_COUNT_WIDTH-1:0] P_MIN = SYNC_COUNT_WIDTH'(SYNC_PERIOD_MIN);
    localparam logic [SYNC_COUNT_WIDTH-1:0] P_ONE = SYNC_COUNT_WIDTH'(1);
    localparam logic [SYNC_COUNT_WIDTH-1:0] P_PW  = SYNC_COUNT_WIDTH'(SYNC_PULSE_WIDTH);

    state_t                      r_state;
    logic                        r_sync;
    logic                        r_done;
    logic [31:0]                 r_pulse_cnt;

    // Shadowed configuration, captured when leaving IDLE
    logic                        r_trig_mode;
    logic [31:0]                 r_delay;
    logic [SYNC_COUNT_WIDTH-1:0] r_period;
    logic [SYNC_COUNT_WIDTH-1:0] r_pw;
    logic [31:0]                 r_burst;

    logic [31:0]                 r_dcnt;
    logic [SYNC_COUNT_WIDTH-1:0] r_pcnt;

    logic                        w_rise;
    logic                        w_trig;
    logic [SYNC_COUNT_WIDTH-1:0] w_period_in;
    logic [SYNC_COUNT_WIDTH-1:0] w_pw_in;
    logic                        w_last;
    logic                        w_burst_end;
    logic                        w_wrap;

    axi_tdd_ng_edge_det u_ext_edge (
        .clk    (clk),
        .resetn (resetn),
        .i_sig  (ext_trig),
        .o_rise (w_rise)
    );

    // A soft strobe and an ext edge in the same cycle collapse into one trigger
    assign w_trig = soft_trig | w_rise;

    // Clamp the period so the pulse always returns low, then bound the width by period-1
    assign w_period_in = (sync_period < P_MIN) ? P_MIN : sync_period;
    assign w_pw_in     = (P_PW < (w_period_in - P_ONE)) ? P_PW : (w_period_in - P_ONE);

    assign w_last      = (r_pcnt == (r_period - P_ONE));
    assign w_burst_end = (r_burst != 32'd0) && (r_pulse_cnt == r_burst) && w_last;

`ifdef AXI_TDD_NG_SYNC_GEN_RESYNC_EN
    // An ext_trig edge while running realigns the period to the external reference
    assign w_wrap = w_last | w_rise;
`else
    assign w_wrap = w_last;
`endif

    // Main sequencer: state, shadow config, delay/period counters and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_sync      <= 1'b0;
            r_done      <= 1'b0;
            r_pulse_cnt <= 32'd0;
            r_trig_mode <= 1'b0;
            r_delay     <= 32'd0;
            r_period    <= '0;
            r_pw        <= '0;
            r_burst     <= 32'd0;
            r_dcnt      <= 32'd0;
            r_pcnt      <= '0;
        end else if (!enable) begin
            // Disable wins over everything and truncates any pulse in flight
            r_state <= IDLE;
            r_sync  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_sync <= 1'b0;
                    // done stays sticky so a finished burst is not re-run until enable toggles
                    if (!r_done) begin
                        r_state     <= ARMED;
                        r_pulse_cnt <= 32'd0;
                        r_trig_mode <= trigger_mode;
                        r_delay     <= startup_delay;
                        r_period    <= w_period_in;
                        r_pw        <= w_pw_in;
                        r_burst     <= burst_count;
                    end
                end
                ARMED: begin
                    r_sync <= 1'b0;
                    if (!r_trig_mode || w_trig) begin
                        r_state <= WAITING;
                        r_dcnt  <= 32'd0;
                    end
                end
                WAITING: begin
                    r_sync <= 1'b0;
                    if (r_dcnt == r_delay) begin
                        r_state <= RUNNING;
                        r_pcnt  <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 32'd1;
                    end
                end
                RUNNING: begin
                    r_sync <= (r_pcnt < r_pw);
                    if ((r_pcnt == '0) && (r_pulse_cnt != 32'hFFFF_FFFF)) begin
                        r_pulse_cnt <= r_pulse_cnt + 32'd1;
                    end
                    if (w_burst_end) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else if (w_wrap) begin
                        r_pcnt <= '0;
                    end else begin
                        r_pcnt <= r_pcnt + P_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_sync  <= 1'b0;
                end
            endcase
        end
    end

    assign sync_out      = r_sync;
    assign state         = r_state;
    assign pulse_counter = r_pulse_cnt;
    assign done          = r_done;

endmodule : axi_tdd_ng_sync_gen

// File: doc/axi_tdd_ng_sync_gen.md
Name: axi_tdd_ng_sync_gen

Overview:
Generates the periodic synchronization pulse train consumed by the TDD engine's sync input. It is the transmitting end of the TDD sync interface. Arms on enable, optionally waits for an external trigger, counts a startup delay, then emits fixed-width pulses every sync_period cycles, either indefinitely or for a programmed burst. Sits in the TDD clock domain next to the TDD core; configuration comes from the register map.

Parameters:
SYNC_COUNT_WIDTH, 64, width of sync_period and the period counter (legal 32..64)
SYNC_PULSE_WIDTH, 1, sync_out high time in clk cycles (legal 1..255)

Ports:
clk  input  1  core clock
resetn  input  1  asynchronous active-low reset
enable  input  1  level; 1 = arm/run, 0 = stop
trigger_mode  input  1  0 = start immediately on arm; 1 = wait for trigger
ext_trig  input  1  external trigger, already synchronous to clk
soft_trig  input  1  single-cycle software trigger strobe
startup_delay  input  32  cycles from trigger to first pulse
sync_period  input  SYNC_COUNT_WIDTH  pulse period in cycles
burst_count  input  32  pulses per run; 0 = infinite
sync_out  output  1  registered sync pulse
state  output  2  current state_t encoding
pulse_counter  output  32  pulses emitted this run
done  output  1  burst finished; sticky until enable = 0

Behaviour:
- One clock; reset is asynchronous, active-low (resetn). Reset values: state IDLE, sync_out 0, pulse_counter 0, done 0, all internal counters 0, ext_trig history 0.
- All outputs are registered; sync_out changes one cycle after the state/counter condition causing it.
- Config shadowing: trigger_mode, startup_delay, sync_period, burst_count latch on the IDLE->ARMED transition. Input changes outside IDLE are ignored until the next arm.
- Period clamp: a latched sync_period < 2 is treated as 2. Effective pulse width = min(SYNC_PULSE_WIDTH, period-1), so sync_out always returns low within each period.
- IDLE: go to ARMED when enable=1 and done=0. pulse_counter clears on this transition.
- ARMED: with trigger_mode=0, go to WAITING the next cycle. With trigger_mode=1, go to WAITING on an ext_trig rising edge (current 1, previous 0) or on soft_trig=1. ext_trig already high when arming does not trigger.
- WAITING: delay counter counts from 0. When count == startup_delay, go to RUNNING with the period counter at 0. startup_delay=0 gives one WAITING cycle.
- RUNNING: period counter counts 0..period-1 and wraps to 0. sync_out=1 while counter < effective pulse width. pulse_counter increments on each counter==0 cycle and saturates at 2^32-1.
- Burst end: when burst_count != 0 and pulse_counter == burst_count and period counter == period-1, go to IDLE and set done=1. done clears only when enable=0, so re-arming needs enable to toggle.
- enable=0 in any state: IDLE next cycle, sync_out 0 next cycle (a pulse in progress is truncated), done cleared. enable=0 has priority over triggers, burst end and resync.
- A soft_trig and an ext_trig edge in the same cycle count as one trigger. Triggers are ignored in IDLE, WAITING and RUNNING, except for the resync feature below.
- Period counter wrap at SYNC_COUNT_WIDTH never occurs, because the counter resets at period-1.

Optional Feature:
AXI_TDD_NG_SYNC_GEN_RESYNC_EN
- Defined: in RUNNING, an ext_trig rising edge forces the period counter to 0 on the next cycle, which starts a new pulse and increments pulse_counter. A coincident burst end takes priority and the block goes to IDLE.
- Undefined: ext_trig is ignored outside ARMED. No resync logic is generated.

Decomposition:
- Reuse state_t (IDLE/ARMED/WAITING/RUNNING) from axi_tdd_ng_pkg.
- Add to axi_tdd_ng_pkg: localparam SYNC_PERIOD_MIN = 2.
- One natural sub-module: axi_tdd_ng_edge_det, a registered rising-edge detector on ext_trig with asynchronous active-low reset. The state machine and counters stay in the top module.

Test Plan:
- Reset mid-RUNNING: resetn low for 3 cycles → state=IDLE, sync_out=0, pulse_counter=0 asynchronously; no pulse after release until enable is seen.
- Immediate start: trigger_mode=0, startup_delay=5, sync_period=10, burst_count=0, enable=1 → first sync_out high exactly 9 cycles after enable is sampled (1 ARMED + 6 WAITING + 1 RUNNING + 1 register), then high 1 of every 10 cycles.
- Triggered burst: trigger_mode=1, ext_trig held high before arm, then low→high → only the rising edge starts the run; burst_count=3, period=4 → exactly 3 pulses, done=1, state=IDLE; enable stays 1 and no re-arm occurs until enable toggles.
- Clamp: sync_period=0 with SYNC_PULSE_WIDTH=4 → period 2, pulse width 1, sync_out alternating 1/0.
- Abort: enable dropped on the first cycle of a pulse with SYNC_PULSE_WIDTH=3 → sync_out low next cycle, state=IDLE; sync_period change while RUNNING has no effect.
- With AXI_TDD_NG_SYNC_GEN_RESYNC_EN defined: period=100, ext_trig edge at counter 37 → pulse restarts the next cycle and pulse_counter increments; without the macro, the same edge causes no change.
